// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared AXI4-Lite types for the command-driven master.
// Response codes plus default-width command/response bundles.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic                    write;
    logic [MAX_ADDR_W-1:0]   addr;
    logic [MAX_DATA_W-1:0]   wdata;
    logic [MAX_DATA_W/8-1:0] wstrb;
  } cmd_t;

  typedef struct packed {
    logic                  write;
    logic [MAX_DATA_W-1:0] rdata;
    resp_t                 resp;
    logic                  timeout;
  } rsp_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic resp_is_err(input resp_t r);
    return r[1];
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master/slave views.
// Widths follow the attached master's ADDR_W/DATA_W.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master executing one read/write per valid/ready command,
// with response timeout and a sticky error state left only by reset.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  err_sticky,
  axi_lite_if.master            m_axi_lite
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam int CNT_W  = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_RSP,
    S_ERR
  } state_t;

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_rready;
  logic                r_awvalid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_wvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_bready;
  logic                r_aw_done;
  logic                r_w_done;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_write;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;
  logic                r_rsp_timeout;
  logic                r_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_to_hit;

  assign w_aw_hs  = r_awvalid & m_axi_lite.awready;
  assign w_w_hs   = r_wvalid & m_axi_lite.wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;
  assign w_to_hit = TO_EN && (r_cnt == TO_LAST);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_awaddr      <= '0;
      r_wvalid      <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_bready      <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_state   <= S_WREQ;
              r_awvalid <= 1'b1;
              r_awaddr  <= cmd_addr;
              r_wvalid  <= 1'b1;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_RADDR;
              r_arvalid <= 1'b1;
              r_araddr  <= cmd_addr;
            end
          end
        end
        S_RADDR: begin
          if (m_axi_lite.arready) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          // A beat on the last counted cycle still beats the timeout.
          if (m_axi_lite.rvalid) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= m_axi_lite.rdata;
            r_rsp_resp    <= m_axi_lite.rresp;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RSP;
          end else if (w_to_hit) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_SLVERR;
            r_rsp_timeout <= 1'b1;
            r_err         <= 1'b1;
            r_state       <= S_RSP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WREQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (m_axi_lite.bvalid) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= m_axi_lite.bresp;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RSP;
          end else if (w_to_hit) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_SLVERR;
            r_rsp_timeout <= 1'b1;
            r_err         <= 1'b1;
            r_state       <= S_RSP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            // Late beats from a timed-out slave are soaked up in ERR.
            if (r_err) begin
              r_state  <= S_ERR;
              r_rready <= 1'b1;
              r_bready <= 1'b1;
            end else begin
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_rsp_write;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;
  assign err_sticky  = r_err;

  assign m_axi_lite.arvalid = r_arvalid;
  assign m_axi_lite.araddr  = r_araddr;
  assign m_axi_lite.rready  = r_rready;
  assign m_axi_lite.awvalid = r_awvalid;
  assign m_axi_lite.awaddr  = r_awaddr;
  assign m_axi_lite.wvalid  = r_wvalid;
  assign m_axi_lite.wdata   = r_wdata;
  assign m_axi_lite.wstrb   = r_wstrb;
  assign m_axi_lite.bready  = r_bready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: delay-programmable slave,
// transaction-level expectations, random and directed traffic.
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        err_sticky;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_cmd_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .aclk(clk),
    .areset(areset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .err_sticky(err_sticky),
    .m_axi_lite(bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave programming for the next transaction
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;

  int          ar_c, r_c, aw_c, w_c, b_c;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  int          viol = 0;
  bit          p_ar, p_aw, p_w;

  always @(negedge clk) begin
    if (areset) begin
      bus.arready = 0; bus.awready = 0; bus.wready = 0;
      bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
      bus.bvalid = 0; bus.bresp = '0;
      ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      p_ar = 0; p_aw = 0; p_w = 0;
    end else begin
      if (p_ar && !bus.arvalid) viol++;
      if (p_aw && !bus.awvalid) viol++;
      if (p_w && !bus.wvalid) viol++;
      if (!bus.arvalid && bus.araddr != 0) viol++;
      if (!bus.awvalid && bus.awaddr != 0) viol++;
      if (!bus.wvalid && (bus.wdata != 0 || bus.wstrb != 0)) viol++;
      bus.arready = 0;
      if (bus.arvalid) begin
        if (ar_c == ar_dly) begin
          bus.arready = 1; cap_araddr = bus.araddr;
          n_ar++; ar_c = 0;
        end else ar_c++;
      end
      bus.awready = 0;
      if (bus.awvalid) begin
        if (aw_c == aw_dly) begin
          bus.awready = 1; cap_awaddr = bus.awaddr;
          n_aw++; aw_c = 0;
        end else aw_c++;
      end
      bus.wready = 0;
      if (bus.wvalid) begin
        if (w_c == w_dly) begin
          bus.wready = 1; cap_wdata = bus.wdata;
          cap_wstrb = bus.wstrb; n_w++; w_c = 0;
        end else w_c++;
      end
      bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
      if (bus.rready) begin
        if (r_c == r_dly) begin
          bus.rvalid = 1; bus.rdata = s_rdata;
          bus.rresp = s_rresp; r_c = 0;
        end else r_c++;
      end else r_c = 0;
      bus.bvalid = 0; bus.bresp = '0;
      if (bus.bready) begin
        if (b_c == b_dly) begin
          bus.bvalid = 1; bus.bresp = s_bresp;
          n_b++; b_c = 0;
        end else b_c++;
      end else b_c = 0;
      p_ar = bus.arvalid && !bus.arready;
      p_aw = bus.awvalid && !bus.awready;
      p_w  = bus.wvalid && !bus.wready;
    end
  end

  bit model_err = 0;

  task automatic run_txn(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         input int hold);
    bit          exp_to;
    int          exp_lat, m, k;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    int          ar0, aw0, w0, b0;
    int unsigned t0;
    if (wr) begin
      m        = (aw_dly > w_dly) ? aw_dly : w_dly;
      exp_to   = (b_dly >= TO);
      exp_lat  = exp_to ? 2 + m + TO : 3 + m + b_dly;
      exp_rd   = '0;
      exp_resp = exp_to ? 2'b10 : s_bresp;
    end else begin
      exp_to   = (r_dly >= TO);
      exp_lat  = exp_to ? 2 + ar_dly + TO : 3 + ar_dly + r_dly;
      exp_rd   = exp_to ? 32'h0 : s_rdata;
      exp_resp = exp_to ? 2'b10 : s_rresp;
    end
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b;
    @(negedge clk);
    chk("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wd; cmd_wstrb = st;
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    k = 0;
    while (!rsp_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_seen", rsp_valid, 1);
    chk("latency", cyc - t0, exp_lat);
    chk("rsp_fields", {rsp_write, rsp_rdata, rsp_resp, rsp_timeout},
        {wr, exp_rd, exp_resp, exp_to});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable",
          {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout},
          {1'b1, wr, exp_rd, exp_resp, exp_to});
      chk("hold_idle", {cmd_ready, bus.arvalid, bus.awvalid,
          bus.wvalid, bus.rready, bus.bready}, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    model_err = model_err | exp_to;
    chk("rsp_dropped", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, !model_err);
    chk("err_sticky", err_sticky, model_err);
    if (wr) begin
      chk("aw_count", n_aw - aw0, 1);
      chk("w_count", n_w - w0, 1);
      chk("awaddr", cap_awaddr, addr);
      chk("wdata", cap_wdata, wd);
      chk("wstrb", cap_wstrb, st);
      if (!exp_to) chk("b_count", n_b - b0, 1);
    end else begin
      chk("ar_count", n_ar - ar0, 1);
      chk("araddr", cap_araddr, addr);
    end
    chk("protocol", viol, 0);
  endtask

  task automatic set_dly(input int a, input int r, input int aw,
                         input int w, input int b);
    ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    areset = 1;
    repeat (n) @(negedge clk);
    areset = 0;
    model_err = 0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    areset = 0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        rsp_timeout}, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid,
        bus.rready, bus.bready}, 0);
    chk("rst_payload", {bus.araddr, bus.awaddr, bus.wdata,
        bus.wstrb}, 0);

    set_dly(0, 0, 0, 0, 0);
    s_rdata = 32'hDEADBEEF; s_rresp = 2'b00;
    run_txn(0, 32'h0000_0010, '0, '0, 5);

    set_dly(0, 0, 0, 3, 0);
    s_bresp = 2'b00;
    run_txn(1, 32'h20, 32'hCAFEF00D, 4'b0011, 0);

    set_dly(1, 2, 0, 0, 0);
    s_rdata = 32'h1234_5678; s_rresp = 2'b11;
    run_txn(0, 32'h40, '0, '0, 1);

    set_dly(0, TO - 1, 0, 0, 0);
    s_rdata = 32'h0BAD_F00D; s_rresp = 2'b00;
    run_txn(0, 32'h44, '0, '0, 0);
    set_dly(0, 0, 2, 0, TO - 1);
    s_bresp = 2'b01;
    run_txn(1, 32'h48, 32'h5555_AAAA, 4'b1111, 0);

    for (int i = 0; i < 40; i++) begin
      set_dly($urandom_range(0, 4), $urandom_range(0, TO - 1),
              $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, TO - 1));
      s_rdata = $urandom;
      s_rresp = 2'($urandom_range(0, 3));
      s_bresp = 2'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
              $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3));
    end

    set_dly(0, 20, 0, 0, 0);
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h80;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = '0;
    @(negedge clk);
    chk("mid_rready", bus.rready, 1);
    areset = 1;
    @(negedge clk);
    chk("mid_rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid,
        bus.rready, bus.bready, rsp_valid}, 0);
    areset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_idle", {rsp_valid, cmd_ready, bus.rready}, 3'b010);
    end
    set_dly(0, 0, 0, 0, 0);
    s_rdata = 32'hFACE_0001; s_rresp = 2'b00;
    run_txn(0, 32'h84, '0, '0, 0);

    set_dly(0, 0, 0, 0, 1000);
    run_txn(1, 32'h90, 32'h0F0F_0F0F, 4'b0101, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("err_state", {cmd_ready, err_sticky, bus.rready,
          bus.bready}, 4'b0111);
    end

    do_reset(2);
    chk("err_cleared", {err_sticky, cmd_ready}, 2'b01);
    set_dly(0, 1, 0, 0, 0);
    s_rdata = 32'h0000_BEEF; s_rresp = 2'b00;
    run_txn(0, 32'hA0, '0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
